packet_router: RTL and testbench

PACKET_ROUTER -- requirements
Module: packet_router

---
 rtl/packet_router_if.sv | 25 ++
 rtl/packet_router.sv | 184 ++++++++++++++++++
 tb/tb_packet_router.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/packet_router_if.sv
// Avalon-ST streaming bundle used on both the sink and source side of the router.
interface avalon_st_if #(
    parameter int DWIDTH        = 64,
    parameter int CHANNEL_WIDTH = 1
) ();
    localparam int EMPTY_WIDTH = (DWIDTH > 8) ? $clog2(DWIDTH / 8) : 1;

    logic [DWIDTH-1:0]        data;
    logic                     valid;
    logic                     ready;
    logic                     startofpacket;
    logic                     endofpacket;
    logic [EMPTY_WIDTH-1:0]   empty;
    logic [CHANNEL_WIDTH-1:0] channel;

    modport sink (
        input  data, valid, startofpacket, endofpacket, empty, channel,
        output ready
    );

    modport src (
        output data, valid, startofpacket, endofpacket, empty, channel,
        input  ready
    );
endinterface

// File: rtl/packet_router.sv
// Store-and-forward packet router: buffers a whole packet, resolves one channel
// for it (including a channel that arrives one cycle after eop), then replays it.
module packet_router #(
    parameter int AST_DWIDTH    = 64,
    parameter int CHANNEL_WIDTH = 1,
    parameter int MAX_PKT_WORDS = 64,
    parameter int DROP_EN       = 0
) (
    input  logic      clk_i,
    input  logic      srst_i,
    avalon_st_if.sink sink_if,
    avalon_st_if.src  src_if,
    output logic      pkt_drop_o
);
    localparam int EW = (AST_DWIDTH > 8) ? $clog2(AST_DWIDTH / 8) : 1;
    localparam int PW = $clog2(MAX_PKT_WORDS);
    localparam logic [PW-1:0] LAST_SLOT = PW'(MAX_PKT_WORDS - 1);
    localparam logic [PW-1:0] PTR_ZERO  = {PW{1'b0}};
    localparam logic [PW-1:0] PTR_ONE   = PW'(1'b1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FILL    = 3'd1,
        RESOLVE = 3'd2,
        DRAIN   = 3'd3,
        DISCARD = 3'd4
    } state_t;

    function automatic logic [CHANNEL_WIDTH-1:0] resolve_chan(input logic [CHANNEL_WIDTH-1:0] acc);
        return {CHANNEL_WIDTH{|acc}};
    endfunction

    logic [AST_DWIDTH-1:0]    mem_data_r  [MAX_PKT_WORDS];
    logic [EW-1:0]            mem_empty_r [MAX_PKT_WORDS];

    state_t                   state_r, state_s;
    logic [PW-1:0]            wr_ptr_r, wr_ptr_s, rd_ptr_r, rd_ptr_s, last_ptr_r, last_ptr_s;
    logic [PW-1:0]            rd_inc_s, wr_addr_s;
    logic [CHANNEL_WIDTH-1:0] chan_acc_r, chan_acc_s;
    logic                     out_valid_r, out_valid_s, out_sop_r, out_sop_s, out_eop_r, out_eop_s;
    logic [AST_DWIDTH-1:0]    out_data_r, out_data_s;
    logic [EW-1:0]            out_empty_r, out_empty_s;
    logic [CHANNEL_WIDTH-1:0] out_chan_r, out_chan_s;
    logic                     ready_r, drop_r, drop_s, wr_en_s, accept_s, start_s;

    assign accept_s = sink_if.valid && ready_r;
    assign start_s  = accept_s && sink_if.startofpacket;
    assign rd_inc_s = rd_ptr_r + PTR_ONE;

    assign sink_if.ready        = ready_r;
    assign src_if.valid         = out_valid_r;
    assign src_if.data          = out_data_r;
    assign src_if.startofpacket = out_sop_r;
    assign src_if.endofpacket   = out_eop_r;
    assign src_if.empty         = out_empty_r;
    assign src_if.channel       = out_chan_r;
    assign pkt_drop_o           = drop_r;

    // Next-state, pointer, buffer-write and prefetched-output logic.
    always_comb begin
        state_s     = state_r;
        wr_ptr_s    = wr_ptr_r;
        rd_ptr_s    = rd_ptr_r;
        last_ptr_s  = last_ptr_r;
        chan_acc_s  = chan_acc_r;
        out_valid_s = out_valid_r;
        out_data_s  = out_data_r;
        out_sop_s   = out_sop_r;
        out_eop_s   = out_eop_r;
        out_empty_s = out_empty_r;
        out_chan_s  = out_chan_r;
        drop_s      = 1'b0;
        wr_en_s     = 1'b0;
        wr_addr_s   = wr_ptr_r;
        case (state_r)
            IDLE, FILL: begin
                // A sop always (re)starts the packet at word 0, even mid-fill.
                if (start_s) begin
                    wr_en_s    = 1'b1;
                    wr_addr_s  = PTR_ZERO;
                    wr_ptr_s   = PTR_ONE;
                    chan_acc_s = sink_if.channel;
                    state_s    = sink_if.endofpacket ? RESOLVE : FILL;
                end else if (accept_s && (state_r == FILL) &&
                             (sink_if.endofpacket || (wr_ptr_r != LAST_SLOT))) begin
                    wr_en_s    = 1'b1;
                    wr_ptr_s   = wr_ptr_r + PTR_ONE;
                    chan_acc_s = chan_acc_r | sink_if.channel;
                    state_s    = sink_if.endofpacket ? RESOLVE : FILL;
                end else if (accept_s && (state_r == FILL)) begin
                    drop_s  = 1'b1;
                    state_s = DISCARD;
                end else begin
                    state_s = state_r;
                end
            end
            RESOLVE: begin
                chan_acc_s = chan_acc_r | sink_if.channel;
                if ((DROP_EN != 0) && (chan_acc_s == {CHANNEL_WIDTH{1'b0}})) begin
                    drop_s  = 1'b1;
                    state_s = IDLE;
                end else begin
                    state_s     = DRAIN;
                    rd_ptr_s    = PTR_ZERO;
                    last_ptr_s  = wr_ptr_r - PTR_ONE;
                    out_valid_s = 1'b1;
                    out_data_s  = mem_data_r[PTR_ZERO];
                    out_sop_s   = 1'b1;
                    out_eop_s   = (last_ptr_s == PTR_ZERO);
                    out_empty_s = mem_empty_r[PTR_ZERO];
                    out_chan_s  = resolve_chan(chan_acc_s);
                end
            end
            DRAIN: begin
                if (src_if.ready && out_eop_r) begin
                    state_s     = IDLE;
                    out_valid_s = 1'b0;
                    out_sop_s   = 1'b0;
                    out_eop_s   = 1'b0;
                    out_chan_s  = {CHANNEL_WIDTH{1'b0}};
                end else if (src_if.ready) begin
                    rd_ptr_s    = rd_inc_s;
                    out_data_s  = mem_data_r[rd_inc_s];
                    out_sop_s   = 1'b0;
                    out_eop_s   = (rd_inc_s == last_ptr_r);
                    out_empty_s = mem_empty_r[rd_inc_s];
                end else begin
                    state_s = DRAIN;
                end
            end
            DISCARD: begin
                if (accept_s && sink_if.endofpacket) begin
                    state_s = IDLE;
                end else begin
                    state_s = DISCARD;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Control and output registers; reset abandons any packet in flight.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_r     <= IDLE;
            wr_ptr_r    <= PTR_ZERO;
            rd_ptr_r    <= PTR_ZERO;
            last_ptr_r  <= PTR_ZERO;
            chan_acc_r  <= {CHANNEL_WIDTH{1'b0}};
            out_valid_r <= 1'b0;
            out_data_r  <= {AST_DWIDTH{1'b0}};
            out_sop_r   <= 1'b0;
            out_eop_r   <= 1'b0;
            out_empty_r <= {EW{1'b0}};
            out_chan_r  <= {CHANNEL_WIDTH{1'b0}};
            ready_r     <= 1'b1;
            drop_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            wr_ptr_r    <= wr_ptr_s;
            rd_ptr_r    <= rd_ptr_s;
            last_ptr_r  <= last_ptr_s;
            chan_acc_r  <= chan_acc_s;
            out_valid_r <= out_valid_s;
            out_data_r  <= out_data_s;
            out_sop_r   <= out_sop_s;
            out_eop_r   <= out_eop_s;
            out_empty_r <= out_empty_s;
            out_chan_r  <= out_chan_s;
            ready_r     <= (state_s != DRAIN);
            drop_r      <= drop_s;
        end
    end

    // Packet buffer storage; contents survive reset since they are rewritten before use.
    always_ff @(posedge clk_i) begin
        if (wr_en_s && !srst_i) begin
            mem_data_r[wr_addr_s]  <= sink_if.data;
            mem_empty_r[wr_addr_s] <= sink_if.empty;
        end
    end
endmodule

// File: tb/tb_packet_router.sv
// Randomised scoreboard bench for packet_router (DROP_EN=1, 4-word buffer).
module tb_packet_router;
    localparam int DW   = 64;
    localparam int CW   = 1;
    localparam int MAXW = 4;

    typedef struct packed {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic [2:0]  empty;
        logic        ch;
    } beat_t;

    logic clk_i  = 1'b0;
    logic srst_i = 1'b1;
    logic pkt_drop_o;

    always #5 clk_i = ~clk_i;

    avalon_st_if #(.DWIDTH(DW), .CHANNEL_WIDTH(CW)) sink_bus ();
    avalon_st_if #(.DWIDTH(DW), .CHANNEL_WIDTH(CW)) src_bus ();

    packet_router #(
        .AST_DWIDTH(DW), .CHANNEL_WIDTH(CW), .MAX_PKT_WORDS(MAXW), .DROP_EN(1)
    ) dut (
        .clk_i(clk_i), .srst_i(srst_i), .sink_if(sink_bus), .src_if(src_bus), .pkt_drop_o(pkt_drop_o)
    );

    int    checks = 0, passed = 0, cyc = 0, drops_seen = 0, drops_exp = 0, eop_cyc = 0;
    bit    rand_ready = 1'b1;
    beat_t exp_q[$];
    int    lat_q[$];
    logic [63:0] pd[8];
    logic        pc[8];
    logic [2:0]  pe[8];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    initial forever begin
        @(posedge clk_i);
        cyc++;
    end

    initial begin
        src_bus.ready = 1'b1;
        forever begin
            @(negedge clk_i);
            src_bus.ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: samples mid-cycle, after the ready driver has settled.
    initial begin : monitor
        beat_t act, held;
        bit prev_valid = 1'b0, was_held = 1'b0;
        forever begin
            @(negedge clk_i);
            #1;
            if (pkt_drop_o === 1'b1) drops_seen++;
            act.data  = src_bus.data;
            act.sop   = src_bus.startofpacket;
            act.eop   = src_bus.endofpacket;
            act.empty = src_bus.empty;
            act.ch    = src_bus.channel;
            if (srst_i) begin
                was_held = 1'b0;
            end else begin
                chk("sink_ready_vs_drain", sink_bus.ready, !src_bus.valid);
                if (was_held) chk("hold_stable", {src_bus.valid, act}, {1'b1, held});
                if (src_bus.valid && !prev_valid) begin
                    chk("latency_queued", lat_q.size() > 0, 1'b1);
                    if (lat_q.size() > 0) chk("first_valid_cycle", cyc, lat_q.pop_front());
                end
                if (src_bus.valid && src_bus.ready) begin
                    chk("beat_queued", exp_q.size() > 0, 1'b1);
                    if (exp_q.size() > 0) chk("beat", act, exp_q.pop_front());
                end
                was_held = src_bus.valid && !src_bus.ready;
                held     = act;
            end
            prev_valid = src_bus.valid;
        end
    end

    task automatic drive_beat(input logic [63:0] d, input logic sop, input logic eop,
                              input logic [2:0] emp, input logic ch);
        int t = 0;
        sink_bus.valid         = 1'b1;
        sink_bus.data          = d;
        sink_bus.startofpacket = sop;
        sink_bus.endofpacket   = eop;
        sink_bus.empty         = emp;
        sink_bus.channel       = ch;
        while (!sink_bus.ready && t < 200) begin
            @(negedge clk_i);
            t++;
        end
        chk("sink_ready_wait", sink_bus.ready, 1'b1);
        if (eop) eop_cyc = cyc;
        @(negedge clk_i);
        sink_bus.valid = 1'b0;
    endtask

    task automatic bubble(input logic ch);
        sink_bus.valid   = 1'b0;
        sink_bus.channel = ch;
        @(negedge clk_i);
    endtask

    // Reference model: whole-packet view of what must come out.
    task automatic send_packet(input int len, input logic lag, input bit noise);
        logic  res = lag;
        beat_t b;
        if (noise && $urandom_range(0, 3) == 0)
            drive_beat({$urandom, $urandom}, 1'b0, 1'b0, 3'($urandom), 1'($urandom));
        if (noise && $urandom_range(0, 3) == 0) begin
            drive_beat({$urandom, $urandom}, 1'b1, 1'b0, 3'($urandom), 1'b1);
            drive_beat({$urandom, $urandom}, 1'b0, 1'b0, 3'($urandom), 1'b1);
        end
        for (int i = 0; i < len; i++) begin
            if (noise && $urandom_range(0, 3) == 0) bubble(1'($urandom));
            drive_beat(pd[i], i == 0, i == len - 1, pe[i], pc[i]);
            res = res | pc[i];
        end
        bubble(lag);
        sink_bus.channel = 1'b0;
        if (len > MAXW || !res) begin
            drops_exp++;
        end else begin
            for (int i = 0; i < len; i++) begin
                b.data = pd[i]; b.sop = (i == 0); b.eop = (i == len - 1);
                b.empty = pe[i]; b.ch = 1'b1;
                exp_q.push_back(b);
            end
            lat_q.push_back(eop_cyc + 2);
        end
    endtask

    task automatic fill_pkt(input int len, input logic [7:0] chmask);
        for (int i = 0; i < len; i++) begin
            pd[i] = {$urandom, $urandom};
            pe[i] = 3'($urandom);
            pc[i] = chmask[i];
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((exp_q.size() > 0 || src_bus.valid) && t < 500) begin
            @(negedge clk_i);
            t++;
        end
        repeat (3) @(negedge clk_i);
        chk("drain_done", exp_q.size(), 0);
    endtask

    initial begin
        int t;
        sink_bus.valid = 1'b0; sink_bus.data = '0; sink_bus.startofpacket = 1'b0;
        sink_bus.endofpacket = 1'b0; sink_bus.empty = 3'd0; sink_bus.channel = 1'b0;
        srst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        chk("rst_valid", src_bus.valid, 1'b0);
        chk("rst_channel", src_bus.channel, 1'b0);
        chk("rst_drop", pkt_drop_o, 1'b0);
        chk("rst_sink_ready", sink_bus.ready, 1'b1);
        srst_i = 1'b0;

        fill_pkt(4, 8'b1000);                      // channel only on beat 3
        send_packet(4, 1'b0, 1'b0);
        wait_idle();
        fill_pkt(3, 8'b0000);                      // channel lags eop by one cycle
        send_packet(3, 1'b1, 1'b0);
        wait_idle();
        fill_pkt(2, 8'b0000);                      // unroutable, must be dropped
        send_packet(2, 1'b0, 1'b0);
        wait_idle();
        chk("drop_zero_channel", drops_seen, drops_exp);
        fill_pkt(6, 8'b111111);                    // overflows the 4-word buffer
        send_packet(6, 1'b0, 1'b0);
        fill_pkt(2, 8'b01);
        send_packet(2, 1'b0, 1'b0);
        wait_idle();
        chk("drop_overflow", drops_seen, drops_exp);

        rand_ready = 1'b0;
        @(negedge clk_i);
        fill_pkt(4, 8'b1111);
        send_packet(4, 1'b0, 1'b0);
        t = 0;
        while (!(src_bus.valid && src_bus.data == pd[2]) && t < 50) begin
            @(negedge clk_i);
            t++;
        end
        chk("rst_mid_beat2", src_bus.data, pd[2]);
        srst_i = 1'b1;
        @(negedge clk_i);
        chk("rst_mid_valid", src_bus.valid, 1'b0);
        chk("rst_mid_channel", src_bus.channel, 1'b0);
        srst_i = 1'b0;
        exp_q.delete();
        lat_q.delete();
        rand_ready = 1'b1;
        fill_pkt(3, 8'b010);
        send_packet(3, 1'b0, 1'b0);
        wait_idle();

        for (int n = 0; n < 120; n++) begin
            int len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                pd[i] = {$urandom, $urandom};
                pe[i] = 3'($urandom);
                pc[i] = ($urandom_range(0, 3) == 0);
            end
            send_packet(len, $urandom_range(0, 3) == 0, 1'b1);
        end
        wait_idle();
        chk("drop_total", drops_seen, drops_exp);
        chk("latency_left", lat_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
